// File: rtl/clock_set_if.sv
// Bundle between the time-setting controller and the calendar counters.
// The counter side drives the live fields. The controller drives the run
// enable, the load strobe and the edited field values.
interface clock_set_if;
  logic [5:0] cur_minute_i;
  logic [4:0] cur_hour_i;
  logic [4:0] cur_day_i;
  logic [4:0] cur_month_i;
  logic       run_en_o;
  logic       load_o;
  logic [5:0] set_minute_o;
  logic [4:0] set_hour_o;
  logic [4:0] set_day_o;
  logic [4:0] set_month_o;

  modport master (
    output cur_minute_i, cur_hour_i, cur_day_i, cur_month_i,
    input  run_en_o, load_o, set_minute_o, set_hour_o, set_day_o, set_month_o
  );

  modport slave (
    input  cur_minute_i, cur_hour_i, cur_day_i, cur_month_i,
    output run_en_o, load_o, set_minute_o, set_hour_o, set_day_o, set_month_o
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// Time-setting controller for the calendar clock.
// The controller debounces the MODE and INC keys, then walks an edit FSM through
// minute, hour, day and month. It freezes the counters while a field is being
// edited, and it loads the edited values into the counters on commit.
//
// state  | meaning
// -------+----------------------------------------------
// RUN    | counters advance, no field edited
// E_MIN  | editing minute
// E_HOUR | editing hour
// E_DAY  | editing day
// E_MON  | editing month, next MODE commits with load_o
module clock_set_ctrl #(
  parameter int DEB_N         = 4,
  parameter int HOLD_TICKS    = 64,
  parameter int REPEAT_TICKS  = 8,
  parameter int TIMEOUT_TICKS = 4096,
  parameter int BLINK_TICKS   = 32,
  parameter int DAY_MAX       = 30,
  parameter int MONTH_MAX     = 11
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick_i,
  input  logic        key_mode_i,
  input  logic        key_inc_i,
  clock_set_if.slave  bus,
  output logic [2:0]  edit_field_o,
  output logic        blink_o
);

  localparam int DW = $clog2(DEB_N) + 1;
  localparam int RW = $clog2(HOLD_TICKS + REPEAT_TICKS + 1);
  localparam int IW = $clog2(TIMEOUT_TICKS + 1);
  localparam int BW = $clog2(BLINK_TICKS + 1);

  // The enum values are the edit_field_o encoding.
  typedef enum logic [2:0] {
    S_RUN    = 3'd0,
    S_E_MIN  = 3'd1,
    S_E_HOUR = 3'd2,
    S_E_DAY  = 3'd3,
    S_E_MON  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            load_d, load_q;
  logic [1:0]      mode_sync, inc_sync;
  logic [1:0]      raw_s, deb, press;
  logic [DW-1:0]   deb_cnt [2];
  logic [RW-1:0]   rep_cnt;
  logic            rep_pulse;
  logic [IW-1:0]   idle_cnt;
  logic [BW-1:0]   blink_cnt;
  logic            mode_evt, inc_evt, any_act, timeout;
  logic [5:0]      set_min;
  logic [4:0]      set_hr, set_day, set_mon;

  // Bring the raw keys into the clock domain with two flops each.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_sync <= '0;
      inc_sync  <= '0;
    end else begin
      mode_sync <= {mode_sync[0], key_mode_i};
      inc_sync  <= {inc_sync[0], key_inc_i};
    end
  end

  // Bit 0 is MODE and bit 1 is INC.
  assign raw_s = {inc_sync[1], mode_sync[1]};

  // Debounce on tick samples. A level flips after DEB_N consecutive differing samples.
  // A flip to 1 produces a 1-clock press pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      deb        <= '0;
      press      <= '0;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      press <= '0;
      if (tick_i) begin
        for (int k = 0; k < 2; k++) begin
          if (raw_s[k] == deb[k]) begin
            deb_cnt[k] <= '0;
          end else if (deb_cnt[k] == DW'(DEB_N - 1)) begin
            deb[k]     <= raw_s[k];
            deb_cnt[k] <= '0;
            press[k]   <= raw_s[k];
          end else begin
            deb_cnt[k] <= deb_cnt[k] + 1'b1;
          end
        end
      end
    end
  end

  // Auto-repeat down-counter. The press loads the hold delay, and each terminal count
  // reloads the repeat period. A release clears the counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rep_cnt   <= '0;
      rep_pulse <= 1'b0;
    end else begin
      rep_pulse <= 1'b0;
      if (!deb[1]) begin
        rep_cnt <= '0;
      end else if (press[1]) begin
        rep_cnt <= RW'(HOLD_TICKS);
      end else if (tick_i && rep_cnt != '0) begin
        if (rep_cnt == RW'(1)) begin
          rep_pulse <= 1'b1;
          rep_cnt   <= RW'(REPEAT_TICKS);
        end else begin
          rep_cnt <= rep_cnt - 1'b1;
        end
      end
    end
  end

  assign mode_evt = press[0];
  assign inc_evt  = (press[1] | rep_pulse) & ~press[0];
  assign any_act  = press[0] | press[1] | rep_pulse;
  assign timeout  = (state_q != S_RUN) && tick_i && (idle_cnt == IW'(1)) && !any_act;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_RUN;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
    end
  end

  // Next-state logic: MODE advances the field, and an idle timeout aborts without a load.
  always_comb begin
    state_d = state_q;
    load_d  = 1'b0;
    case (state_q)
      S_RUN:    if (mode_evt) state_d = S_E_MIN;
      S_E_MIN:  if (mode_evt) state_d = S_E_HOUR; else if (timeout) state_d = S_RUN;
      S_E_HOUR: if (mode_evt) state_d = S_E_DAY;  else if (timeout) state_d = S_RUN;
      S_E_DAY:  if (mode_evt) state_d = S_E_MON;  else if (timeout) state_d = S_RUN;
      S_E_MON: begin
        if (mode_evt) begin
          state_d = S_RUN;
          load_d  = 1'b1;
        end else if (timeout) begin
          state_d = S_RUN;
        end
      end
      default:  state_d = S_RUN;
    endcase
  end

  // Edited fields. Entering the edit copies the live fields, and INC bumps only the
  // selected field modulo its range.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      set_min <= '0;
      set_hr  <= '0;
      set_day <= '0;
      set_mon <= '0;
    end else if (state_q == S_RUN && mode_evt) begin
      set_min <= bus.cur_minute_i;
      set_hr  <= bus.cur_hour_i;
      set_day <= bus.cur_day_i;
      set_mon <= bus.cur_month_i;
    end else if (inc_evt) begin
      case (state_q)
        S_E_MIN:  set_min <= (set_min == 6'd59) ? 6'd0 : set_min + 1'b1;
        S_E_HOUR: set_hr  <= (set_hr == 5'd23) ? 5'd0 : set_hr + 1'b1;
        S_E_DAY:  set_day <= (set_day == 5'(DAY_MAX)) ? 5'd0 : set_day + 1'b1;
        S_E_MON:  set_mon <= (set_mon == 5'(MONTH_MAX)) ? 5'd0 : set_mon + 1'b1;
        default:  ;
      endcase
    end
  end

  // Idle timeout down-counter. Any key activity rearms it, and it is cleared in RUN.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idle_cnt <= '0;
    end else if (state_d == S_RUN) begin
      idle_cnt <= '0;
    end else if (any_act || state_q == S_RUN) begin
      idle_cnt <= IW'(TIMEOUT_TICKS);
    end else if (tick_i) begin
      idle_cnt <= idle_cnt - 1'b1;
    end
  end

  // Blink half-period timer. It restarts low on every field change and is held low in RUN.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      blink_o   <= 1'b0;
      blink_cnt <= '0;
    end else if (state_d == S_RUN) begin
      blink_o   <= 1'b0;
      blink_cnt <= '0;
    end else if (state_d != state_q) begin
      blink_o   <= 1'b0;
      blink_cnt <= BW'(BLINK_TICKS);
    end else if (tick_i) begin
      if (blink_cnt == BW'(1)) begin
        blink_o   <= ~blink_o;
        blink_cnt <= BW'(BLINK_TICKS);
      end else begin
        blink_cnt <= blink_cnt - 1'b1;
      end
    end
  end

  assign bus.run_en_o     = (state_q == S_RUN);
  assign bus.load_o       = load_q;
  assign bus.set_minute_o = set_min;
  assign bus.set_hour_o   = set_hr;
  assign bus.set_day_o    = set_day;
  assign bus.set_month_o  = set_mon;
  assign edit_field_o     = state_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: a table of key actions with expected fields,
// followed by hand-written auto-repeat, timeout, glitch, same-cycle and reset sequences.
module tb_clock_set_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       tick_i = 1'b0;
  logic       key_mode_i = 1'b0;
  logic       key_inc_i = 1'b0;
  logic [2:0] edit_field_o;
  logic       blink_o;
  logic [1:0] tdiv = '0;
  int         tick_count = 0;
  int         checks = 0;
  int         errors = 0;
  int         load_cnt = 0;
  int         load_long = 0;
  int         blink_tog = 0;
  logic       load_prev = 1'b0;
  logic       blink_prev = 1'b0;

  clock_set_if bus();

  clock_set_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .tick_i       (tick_i),
    .key_mode_i   (key_mode_i),
    .key_inc_i    (key_inc_i),
    .bus          (bus),
    .edit_field_o (edit_field_o),
    .blink_o      (blink_o)
  );

  always #5 clock = ~clock;

  // One tick every 4 clocks. tick_count counts the ticks the DUT has seen.
  always @(posedge clock) begin
    tdiv   <= tdiv + 1'b1;
    tick_i <= (tdiv == 2'd3);
    if (tick_i) tick_count <= tick_count + 1;
  end

  // Count load pulses and any load pulse longer than one cycle. Also count blink edges.
  always @(negedge clock) begin
    if (bus.load_o) load_cnt <= load_cnt + 1;
    if (bus.load_o && load_prev) load_long <= load_long + 1;
    if (blink_o != blink_prev) blink_tog <= blink_tog + 1;
    load_prev  <= bus.load_o;
    blink_prev <= blink_o;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [5:0] cmin;
    logic [4:0] chr, cday, cmon;
    logic       mode, inc;
    logic [2:0] ef;
    logic       er;
    logic [5:0] emin;
    logic [4:0] ehr, eday, emon;
    int         eloads;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  function automatic vec_t mk(int cm, int ch, int cd, int cmo, bit m, bit i,
                              int ef, int er, int em, int eh, int ed, int emo, int el);
    vec_t v;
    v.cmin = 6'(cm); v.chr = 5'(ch); v.cday = 5'(cd); v.cmon = 5'(cmo);
    v.mode = m; v.inc = i;
    v.ef = 3'(ef); v.er = er[0];
    v.emin = 6'(em); v.ehr = 5'(eh); v.eday = 5'(ed); v.emon = 5'(emo);
    v.eloads = el;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int target;
    target = tick_count + n;
    while (tick_count < target) @(negedge clock);
  endtask

  // Hold the raw keys for n ticks, then release and let the debounced level settle.
  task automatic press(input logic m, input logic i, input int n);
    @(negedge clock);
    key_mode_i = m;
    key_inc_i  = i;
    wait_ticks(n);
    key_mode_i = 1'b0;
    key_inc_i  = 1'b0;
    wait_ticks(6);
  endtask

  task automatic set_cur(input int m, input int h, input int d, input int mo);
    bus.cur_minute_i = 6'(m);
    bus.cur_hour_i   = 5'(h);
    bus.cur_day_i    = 5'(d);
    bus.cur_month_i  = 5'(mo);
  endtask

  function automatic logic [63:0] snap();
    return {31'd0, edit_field_o, bus.run_en_o, bus.set_minute_o, bus.set_hour_o,
            bus.set_day_o, bus.set_month_o, 8'(load_cnt)};
  endfunction

  function automatic logic [63:0] want(int ef, int er, int m, int h, int d, int mo, int l);
    return {31'd0, 3'(ef), er[0], 6'(m), 5'(h), 5'(d), 5'(mo), 8'(l)};
  endfunction

  int loads_before, tog_before;

  initial begin
    //           cur m  h  d  mo  M  I   ef er  min hr day mon loads
    vecs[0]  = mk(34, 12, 5, 3,  1, 0,  1, 0,  34, 12, 5, 3, 0);
    vecs[1]  = mk(34, 12, 5, 3,  0, 1,  1, 0,  35, 12, 5, 3, 0);
    vecs[2]  = mk(34, 12, 5, 3,  1, 0,  2, 0,  35, 12, 5, 3, 0);
    vecs[3]  = mk(34, 12, 5, 3,  0, 1,  2, 0,  35, 13, 5, 3, 0);
    vecs[4]  = mk(34, 12, 5, 3,  1, 0,  3, 0,  35, 13, 5, 3, 0);
    vecs[5]  = mk(34, 12, 5, 3,  0, 1,  3, 0,  35, 13, 6, 3, 0);
    vecs[6]  = mk(34, 12, 5, 3,  1, 0,  4, 0,  35, 13, 6, 3, 0);
    vecs[7]  = mk(34, 12, 5, 3,  0, 1,  4, 0,  35, 13, 6, 4, 0);
    vecs[8]  = mk(34, 12, 5, 3,  1, 0,  0, 1,  35, 13, 6, 4, 1);
    vecs[9]  = mk(58, 12, 5, 3,  1, 0,  1, 0,  58, 12, 5, 3, 1);
    vecs[10] = mk(58, 12, 5, 3,  0, 1,  1, 0,  59, 12, 5, 3, 1);
    vecs[11] = mk(58, 12, 5, 3,  0, 1,  1, 0,   0, 12, 5, 3, 1);
    vecs[12] = mk(58, 12, 5, 3,  1, 0,  2, 0,   0, 12, 5, 3, 1);
    vecs[13] = mk(58, 12, 5, 3,  0, 1,  2, 0,   0, 13, 5, 3, 1);
    vecs[14] = mk(58, 12, 5, 3,  1, 0,  3, 0,   0, 13, 5, 3, 1);
    vecs[15] = mk(58, 12, 5, 3,  1, 0,  4, 0,   0, 13, 5, 3, 1);
    vecs[16] = mk(58, 12, 5, 3,  1, 0,  0, 1,   0, 13, 5, 3, 2);
    vecs[17] = mk(58, 12, 5, 3,  0, 1,  0, 1,   0, 13, 5, 3, 2);
    vecs[18] = mk( 0, 23, 30, 11, 1, 0, 1, 0,   0, 23, 30, 11, 2);
    vecs[19] = mk( 0, 23, 30, 11, 1, 0, 2, 0,   0, 23, 30, 11, 2);
    vecs[20] = mk( 0, 23, 30, 11, 0, 1, 2, 0,   0,  0, 30, 11, 2);
    vecs[21] = mk( 0, 23, 30, 11, 1, 0, 3, 0,   0,  0, 30, 11, 2);
    vecs[22] = mk( 0, 23, 30, 11, 0, 1, 3, 0,   0,  0,  0, 11, 2);
    vecs[23] = mk( 0, 23, 30, 11, 1, 0, 4, 0,   0,  0,  0, 11, 2);
    vecs[24] = mk( 0, 23, 30, 11, 0, 1, 4, 0,   0,  0,  0,  0, 2);
    vecs[25] = mk( 0, 23, 30, 11, 1, 0, 0, 1,   0,  0,  0,  0, 3);

    set_cur(0, 0, 0, 0);
    repeat (3) @(negedge clock);
    check("reset_state", {blink_o, snap()}, {1'b0, want(0, 1, 0, 0, 0, 0, 0)});
    reset = 1'b1;
    repeat (4) @(negedge clock);

    for (int k = 0; k < NV; k++) begin
      set_cur(int'(vecs[k].cmin), int'(vecs[k].chr), int'(vecs[k].cday), int'(vecs[k].cmon));
      press(vecs[k].mode, vecs[k].inc, 6);
      check($sformatf("vec%0d", k), snap(),
            want(int'(vecs[k].ef), int'(vecs[k].er), int'(vecs[k].emin), int'(vecs[k].ehr),
                 int'(vecs[k].eday), int'(vecs[k].emon), vecs[k].eloads));
    end

    // Auto-repeat: about 84 debounced-high ticks gives the press plus 3 repeats (22->23->0->1->2).
    set_cur(7, 22, 9, 2);
    press(1'b1, 1'b0, 6);
    press(1'b1, 1'b0, 6);
    check("hold_start", snap(), want(2, 0, 7, 22, 9, 2, 3));
    press(1'b0, 1'b1, 84);
    check("hold_repeat", snap(), want(2, 0, 7, 2, 9, 2, 3));

    // Timeout: E_DAY survives about 4088 idle ticks, then aborts without a load.
    press(1'b1, 1'b0, 6);
    tog_before = blink_tog;
    wait_ticks(4080);
    check("timeout_not_yet", snap(), want(3, 0, 7, 2, 9, 2, 3));
    check("blink_toggles", 64'(blink_tog - tog_before), 64'd127);
    wait_ticks(20);
    check("timeout_abort", snap(), want(0, 1, 7, 2, 9, 2, 3));
    check("blink_run_low", {63'd0, blink_o}, 64'd0);

    // A 2-tick MODE glitch is shorter than the debounce window.
    press(1'b1, 1'b0, 2);
    check("mode_glitch", snap(), want(0, 1, 7, 2, 9, 2, 3));

    // MODE and INC together: MODE wins, and the minute is untouched.
    set_cur(40, 1, 1, 1);
    press(1'b1, 1'b0, 6);
    press(1'b1, 1'b1, 6);
    check("mode_beats_inc", snap(), want(2, 0, 40, 1, 1, 1, 3));

    // Reset in E_MON discards the edit without a load.
    press(1'b1, 1'b0, 6);
    press(1'b1, 1'b0, 6);
    check("in_emon", snap(), want(4, 0, 40, 1, 1, 1, 3));
    loads_before = load_cnt;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("reset_mid_edit", {blink_o, snap()}, {1'b0, want(0, 1, 0, 0, 0, 0, loads_before)});
    @(negedge clock);
    reset = 1'b1;
    wait_ticks(10);
    check("after_reset", snap(), want(0, 1, 0, 0, 0, 0, 3));
    check("load_one_cycle", 64'(load_long), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
